secuenciador_volcado_rtc: RTL and testbench

Burst-write sequencer between the local time/date/timer register bank and the RTC bus controller. On a start pulse it snapshots the local registers and then issues one write transaction per register, in address order, over a request/acknowledge handshake. A mode input selects the full bank, only the time/date group, or only the timer group. An ack watchdog and an abort input ensure the block always returns to idle.

---
 rtl/secuenciador_volcado_rtc.sv | 155 +++++++++++++++
 tb/tb_secuenciador_volcado_rtc.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_volcado_rtc.sv
// secuenciador_volcado_rtc
//   Burst-write sequencer from the local time/date/timer register bank to the
//   RTC bus controller. A start pulse snapshots in_regs. The block then issues
//   one write per register, in index order, over a wr_req/wr_ack handshake.
//   modo picks the full bank (00), the time/date group (01) or the timer
//   group (10). modo 11 is rejected with an error pulse.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, abort, modo    burst control
//   in_regs               flattened local registers, reg i at [i*DATA_W +: DATA_W]
//   wr_ack                write-complete pulse from the bus controller
//   wr_req, out_addr_rtc, out_dato_rtc   current write request
//   busy, done, error     status (done/error are single-cycle pulses)
module secuenciador_volcado_rtc #(
  parameter int          DATA_W         = 8,
  parameter int          N_REGS         = 10,
  parameter int          TIMER_FIRST    = 7,
  parameter logic [7:0]  RTC_BASE_HORA  = 8'h21,
  parameter logic [7:0]  RTC_BASE_TIMER = 8'h41,
  parameter int          TIMEOUT_CYC    = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               modo,
  input  logic [N_REGS*DATA_W-1:0] in_regs,
  input  logic                     wr_ack,
  output logic                     wr_req,
  output logic [7:0]               out_addr_rtc,
  output logic [DATA_W-1:0]        out_dato_rtc,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  localparam int IDX_W = $clog2(N_REGS + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           last_q, last_d;
  logic [N_REGS*DATA_W-1:0]   snap_q, snap_d;
  logic [15:0]                wd_q, wd_d;
  logic                       err_q, err_d;
  logic [7:0]                 addr_q, addr_d;
  logic [DATA_W-1:0]          dato_q, dato_d;
  logic                       ld;

  // Local index -> RTC address; the two groups live at unrelated bases.
  function automatic logic [7:0] rtc_addr(input logic [IDX_W-1:0] i);
    if (int'(i) < TIMER_FIRST) return RTC_BASE_HORA + 8'(i);
    else                       return RTC_BASE_TIMER + 8'(int'(i) - TIMER_FIRST);
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    snap_d  = snap_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    dato_d  = dato_q;
    ld      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (modo == 2'b11) begin
            err_d = 1'b1;
          end else begin
            snap_d  = in_regs;
            wd_d    = '0;
            ld      = 1'b1;
            state_d = S_REQ;
            case (modo)
              2'b01: begin
                idx_d  = '0;
                last_d = IDX_W'(TIMER_FIRST - 1);
              end
              2'b10: begin
                idx_d  = IDX_W'(TIMER_FIRST);
                last_d = IDX_W'(N_REGS - 1);
              end
              default: begin
                idx_d  = '0;
                last_d = IDX_W'(N_REGS - 1);
              end
            endcase
          end
        end
      end
      S_REQ: begin
        // abort outranks both ack and the watchdog
        if (abort) begin
          state_d = S_IDLE;
        end else if (wr_ack) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            ld      = 1'b1;
            state_d = S_GAP;
          end
        end else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
          // this is the TIMEOUT_CYC-th REQ cycle without an ack
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_GAP: begin
        wd_d    = '0;
        state_d = abort ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    // Address/data move only on load or advance, so they hold through REQ.
    if (ld) begin
      addr_d = rtc_addr(idx_d);
      dato_d = snap_d[idx_d*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      snap_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      snap_q  <= snap_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dato_q  <= dato_d;
    end
  end

  assign wr_req       = (state_q == S_REQ);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = err_q;
  assign out_addr_rtc = addr_q;
  assign out_dato_rtc = dato_q;

endmodule

// File: tb/tb_secuenciador_volcado_rtc.sv
module tb_secuenciador_volcado_rtc;
  localparam int N = 10;
  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic           clk = 1'b0;
  logic           reset_n, start, abort, wr_ack;
  logic [1:0]     modo;
  logic [N*W-1:0] in_regs;
  logic           wr_req, busy, done, error;
  logic [7:0]     out_addr_rtc;
  logic [W-1:0]   out_dato_rtc;

  int  vectors = 0, miscompares = 0;
  int  done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  bit  ack_auto = 1'b0;
  int  ack_dly = 1;
  int  req_cyc = 0;
  wr_t sb[$];

  secuenciador_volcado_rtc dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .modo(modo),
    .in_regs(in_regs), .wr_ack(wr_ack), .wr_req(wr_req),
    .out_addr_rtc(out_addr_rtc), .out_dato_rtc(out_dato_rtc),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_addr(input int i);
    if (i < 7) return 8'h21 + 8'(i);
    else       return 8'h41 + 8'(i - 7);
  endfunction

  task automatic push_range(input int first, input int last, input logic [N*W-1:0] regs);
    for (int i = first; i <= last; i++) begin
      wr_t e;
      e.a = exp_addr(i);
      e.d = regs[i*W +: W];
      sb.push_back(e);
    end
  endtask

  // Automatic ack responder: ack ack_dly cycles after wr_req rises.
  initial forever begin
    @(posedge clk); #1;
    if (ack_auto) wr_ack = (wr_req && req_cyc == ack_dly);
    req_cyc = wr_req ? req_cyc + 1 : 0;
  end

  // Monitor / scoreboard consumer, sampled on the falling edge.
  logic       req_prev = 1'b0;
  logic [7:0] addr_prev = '0, dato_prev = '0;
  initial forever begin
    @(negedge clk);
    if (done || error) begin
      vectors++;
      if (done && error) begin
        miscompares++;
        $display("FAIL done_error_overlap done=%b error=%b required not both", done, error);
      end
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (wr_req && !req_prev) begin
      wr_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write", out_addr_rtc, out_dato_rtc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if ({out_addr_rtc, out_dato_rtc} !== {e.a, e.d}) begin
          miscompares++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   out_addr_rtc, out_dato_rtc, e.a, e.d);
        end
      end
    end
    if (wr_req && req_prev) begin
      vectors++;
      if ({out_addr_rtc, out_dato_rtc} !== {addr_prev, dato_prev}) begin
        miscompares++;
        $display("FAIL req_stable got addr=%h data=%h required addr=%h data=%h",
                 out_addr_rtc, out_dato_rtc, addr_prev, dato_prev);
      end
    end
    req_prev  = wr_req;
    addr_prev = out_addr_rtc;
    dato_prev = out_dato_rtc;
  end

  task automatic do_start(input logic [1:0] m);
    @(posedge clk); #1;
    modo  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    while (busy && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = !busy;
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({wr_req, busy, done, error, out_addr_rtc, out_dato_rtc} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h required 0",
               {wr_req, busy, done, error, out_addr_rtc, out_dato_rtc});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({wr_req, busy, done, error} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b required 0000", {wr_req, busy, done, error});
    end
  endtask

  task automatic test_mode00;
    bit ok;
    for (int i = 0; i < N; i++) in_regs[i*W +: W] = 8'h10 + 8'(i);
    ack_auto = 1'b1; ack_dly = 1;
    done_cnt = 0; err_cnt = 0;
    push_range(0, 9, in_regs);
    do_start(2'b00);
    vectors++;
    if ({wr_req, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_latency got req/busy=%b required 11", {wr_req, busy});
    end
    wait_idle(200, ok);
    @(posedge clk); #1;
    vectors++;
    if (!ok || done_cnt != 1 || err_cnt != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL mode00 got idle=%0b done=%0d err=%0d left=%0d required 1/1/0/0",
               ok, done_cnt, err_cnt, sb.size());
    end
  endtask

  task automatic test_snapshot;
    bit ok;
    logic [N*W-1:0] snap;
    for (int i = 0; i < N; i++) in_regs[i*W +: W] = 8'h10 + 8'(i);
    snap = in_regs;
    done_cnt = 0;
    push_range(7, 9, snap);
    do_start(2'b10);
    in_regs = ~snap;
    wait_idle(100, ok);
    @(posedge clk); #1;
    vectors++;
    if (!ok || done_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL snapshot got idle=%0b done=%0d left=%0d required 1/1/0", ok, done_cnt, sb.size());
    end
    in_regs = snap;
  endtask

  task automatic test_back_to_back;
    int cyc = 1;
    ack_auto = 1'b1; ack_dly = 0;
    done_cnt = 0;
    push_range(7, 9, in_regs);
    do_start(2'b10);
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (cyc != 6) begin
      miscompares++;
      $display("FAIL best_case_latency got done in cycle %0d required 6", cyc);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL best_case_end got busy=%b done=%b cnt=%0d left=%0d required 0/0/1/0",
               busy, done, done_cnt, sb.size());
    end
    ack_dly = 1;
  endtask

  task automatic test_timeout;
    int cnt = 0;
    ack_auto = 1'b0; wr_ack = 1'b0;
    done_cnt = 0; err_cnt = 0; wr_cnt = 0;
    push_range(0, 0, in_regs);
    do_start(2'b01);
    while (wr_req && cnt < 400) begin
      cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (cnt != 255) begin
      miscompares++;
      $display("FAIL timeout_cycles got %0d required 255", cnt);
    end
    vectors++;
    if ({error, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_pulse got error/busy=%b required 10", {error, busy});
    end
    @(posedge clk); #1;
    vectors++;
    if (error !== 1'b0 || err_cnt != 1 || done_cnt != 0 || wr_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_end got err=%b errs=%0d dones=%0d writes=%0d required 0/1/0/1",
               error, err_cnt, done_cnt, wr_cnt);
    end
  endtask

  task automatic test_bad_mode;
    err_cnt = 0; wr_cnt = 0;
    do_start(2'b11);
    vectors++;
    if ({error, busy, wr_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL bad_mode got error/busy/req=%b required 100", {error, busy, wr_req});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (error !== 1'b0 || err_cnt != 1 || wr_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_mode_end got err=%b errs=%0d writes=%0d busy=%b required 0/1/0/0",
               error, err_cnt, wr_cnt, busy);
    end
  endtask

  task automatic test_abort;
    bit ok;
    ack_auto = 1'b0; wr_ack = 1'b0;
    done_cnt = 0; err_cnt = 0;
    push_range(0, 2, in_regs);
    do_start(2'b00);
    for (int w = 0; w < 3; w++) begin
      wr_ack = 1'b1;
      if (w == 2) abort = 1'b1;
      @(posedge clk); #1;
      wr_ack = 1'b0;
      abort  = 1'b0;
      if (w < 2) begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if ({busy, wr_req} !== 2'b00 || out_addr_rtc !== 8'h23 || out_dato_rtc !== in_regs[2*W +: W]) begin
      miscompares++;
      $display("FAIL abort_state got busy/req=%b addr=%h data=%h required 00 23 %h",
               {busy, wr_req}, out_addr_rtc, out_dato_rtc, in_regs[2*W +: W]);
    end
    @(posedge clk); #1;
    vectors++;
    if (done_cnt != 0 || err_cnt != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL abort_pulses got done=%0d err=%0d left=%0d required 0/0/0",
               done_cnt, err_cnt, sb.size());
    end
    ack_auto = 1'b1;
    push_range(0, 6, in_regs);
    do_start(2'b01);
    wait_idle(100, ok);
    @(posedge clk); #1;
    vectors++;
    if (!ok || done_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL abort_restart got idle=%0b done=%0d left=%0d required 1/1/0", ok, done_cnt, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int c = 0;
    ack_auto = 1'b1;
    done_cnt = 0; err_cnt = 0; wr_cnt = 0;
    push_range(0, 9, in_regs);
    do_start(2'b00);
    while (wr_cnt < 3 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({wr_req, busy, done, error, out_addr_rtc, out_dato_rtc} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid got %h required 0", {wr_req, busy, done, error, out_addr_rtc, out_dato_rtc});
    end
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done_cnt != 0 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_mid_end got busy=%b done=%0d err=%0d required 0/0/0", busy, done_cnt, err_cnt);
    end
    wr_cnt = 0;
    push_range(7, 9, in_regs);
    do_start(2'b10);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      modo  = (k == 1) ? 2'b11 : 2'b00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle(100, ok);
    @(posedge clk); #1;
    vectors++;
    if (!ok || wr_cnt != 3 || done_cnt != 1 || err_cnt != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL start_while_busy got idle=%0b writes=%0d done=%0d err=%0d required 1/3/1/0",
               ok, wr_cnt, done_cnt, err_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; wr_ack = 1'b0;
    modo = 2'b00; in_regs = '0;
    test_reset();
    test_mode00();
    test_snapshot();
    test_back_to_back();
    test_timeout();
    test_bad_mode();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
